// File: rtl/gun_pkg.sv
// Shared calendar constants and month-length helpers for the day-of-month counter.
package gun_pkg;

  localparam logic [3:0] OCAK    = 4'd1;
  localparam logic [3:0] SUBAT   = 4'd2;
  localparam logic [3:0] MART    = 4'd3;
  localparam logic [3:0] NISAN   = 4'd4;
  localparam logic [3:0] MAYIS   = 4'd5;
  localparam logic [3:0] HAZIRAN = 4'd6;
  localparam logic [3:0] TEMMUZ  = 4'd7;
  localparam logic [3:0] AGUSTOS = 4'd8;
  localparam logic [3:0] EYLUL   = 4'd9;
  localparam logic [3:0] EKIM    = 4'd10;
  localparam logic [3:0] KASIM   = 4'd11;
  localparam logic [3:0] ARALIK  = 4'd12;

  localparam logic [4:0] UZ_28 = 5'd28;
  localparam logic [4:0] UZ_29 = 5'd29;
  localparam logic [4:0] UZ_30 = 5'd30;
  localparam logic [4:0] UZ_31 = 5'd31;

  // Invalid month codes fall into the default branch and get 31 days.
  function automatic logic [4:0] ay_uzunluk(input logic [3:0] m, input logic leap,
                                            input int unsigned leap_en,
                                            input int unsigned fixed_len);
    logic [4:0] len;
    if (fixed_len != 0) begin
      len = fixed_len[4:0];
    end else begin
      case (m)
        NISAN, HAZIRAN, EYLUL, KASIM: len = UZ_30;
        SUBAT:                        len = (leap_en != 0 && leap) ? UZ_29 : UZ_28;
        default:                      len = UZ_31;
      endcase
    end
    return len;
  endfunction

  function automatic logic [3:0] onceki_ay(input logic [3:0] m);
    return (m == OCAK || m == 4'd0 || m > ARALIK) ? ARALIK : m - 4'd1;
  endfunction

endpackage

// File: rtl/ay_uzunluk_lut.sv
// Combinational month-length lookup: number of days in month ay.
module ay_uzunluk_lut
  import gun_pkg::*;
#(
  parameter int unsigned FIXED_LEN = 0,
  parameter int unsigned LEAP_EN   = 1
) (
  input  logic [3:0] ay,
  input  logic       leap,
  output logic [4:0] uzunluk
);

  assign uzunluk = ay_uzunluk(ay, leap, LEAP_EN, FIXED_LEN);

endmodule

// File: rtl/gun_takvim.sv
// Day-of-month counter 1..len(ay) with tick/button stepping, direct load and
// one-cycle month carry/borrow pulses.
module gun_takvim
  import gun_pkg::*;
#(
  parameter int unsigned DAY_W     = 6,
  parameter int unsigned FIXED_LEN = 0,
  parameter int unsigned LEAP_EN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic             tick,
  input  logic             gun_arttir,
  input  logic             gun_azalt,
  input  logic [3:0]       ay,
  input  logic             leap,
  input  logic             load,
  input  logic [DAY_W-1:0] load_val,
  output logic [DAY_W-1:0] gun,
  output logic             ay_arttir,
  output logic             ay_azalt,
  output logic             gun_son
);

  localparam logic [DAY_W-1:0] Bir = DAY_W'(1);

  logic [4:0]       uz_cur, uz_prev;
  logic [DAY_W-1:0] len_cur, len_prev;
  logic [DAY_W-1:0] gun_q, gun_d, gun_up, gun_dn;
  logic             arttir_q, arttir_d, azalt_q, azalt_d;
  logic             arm_q, arm_d, pend_q, pend_d;
  logic             wrap_up, wrap_dn, btn_act, tick_ev;

  ay_uzunluk_lut #(
    .FIXED_LEN(FIXED_LEN),
    .LEAP_EN  (LEAP_EN)
  ) u_len_cur (
    .ay     (ay),
    .leap   (leap),
    .uzunluk(uz_cur)
  );

  ay_uzunluk_lut #(
    .FIXED_LEN(FIXED_LEN),
    .LEAP_EN  (LEAP_EN)
  ) u_len_prev (
    .ay     (onceki_ay(ay)),
    .leap   (leap),
    .uzunluk(uz_prev)
  );

  assign len_cur  = DAY_W'(uz_cur);
  assign len_prev = DAY_W'(uz_prev);

  assign wrap_up = (gun_q >= len_cur);
  assign gun_up  = wrap_up ? Bir : gun_q + Bir;
  assign wrap_dn = (gun_q <= Bir);
  assign gun_dn  = wrap_dn ? len_prev : gun_q - Bir;

  assign btn_act = arm_q && (gun_arttir ^ gun_azalt);
  assign tick_ev = (tick || pend_q) && !stop;

  always_comb begin
    gun_d    = gun_q;
    arttir_d = 1'b0;
    azalt_d  = 1'b0;
    pend_d   = pend_q;
    // Any held button disarms; only a full release re-arms.
    arm_d    = !(gun_arttir || gun_azalt);
    if (load) begin
      if (load_val == '0)          gun_d = Bir;
      else if (load_val > len_cur) gun_d = len_cur;
      else                         gun_d = load_val;
      if (tick_ev) pend_d = 1'b1;
    end else if (btn_act) begin
      if (gun_arttir) begin
        gun_d    = gun_up;
        arttir_d = wrap_up;
      end else begin
        gun_d   = gun_dn;
        azalt_d = wrap_dn;
      end
      if (tick_ev) pend_d = 1'b1;
    end else if (tick_ev) begin
      gun_d    = gun_up;
      arttir_d = wrap_up;
      pend_d   = 1'b0;
    end else if (gun_q > len_cur) begin
      gun_d = len_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gun_q    <= Bir;
      arttir_q <= 1'b0;
      azalt_q  <= 1'b0;
      arm_q    <= 1'b1;
      pend_q   <= 1'b0;
    end else begin
      gun_q    <= gun_d;
      arttir_q <= arttir_d;
      azalt_q  <= azalt_d;
      arm_q    <= arm_d;
      pend_q   <= pend_d;
    end
  end

  assign gun       = gun_q;
  assign ay_arttir = arttir_q;
  assign ay_azalt  = azalt_q;
  assign gun_son   = (gun_q == len_cur);

endmodule

// File: tb/tb_gun_takvim.sv
// Bench for gun_takvim: directed calendar cases plus random stimulus against
// a behavioural day-counter model (calendar and fixed-30 instances).
module tb_gun_takvim;

  logic       clk = 1'b0;
  logic       reset, stop, tick, gun_arttir, gun_azalt, leap, load;
  logic [3:0] ay;
  logic [5:0] load_val;
  logic [5:0] gun_c, gun_f;
  logic       arttir_c, azalt_c, son_c, arttir_f, azalt_f, son_f;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  gun_takvim u_dut (
    .clk(clk), .reset(reset), .stop(stop), .tick(tick), .gun_arttir(gun_arttir),
    .gun_azalt(gun_azalt), .ay(ay), .leap(leap), .load(load), .load_val(load_val),
    .gun(gun_c), .ay_arttir(arttir_c), .ay_azalt(azalt_c), .gun_son(son_c)
  );

  gun_takvim #(.FIXED_LEN(30)) u_fix (
    .clk(clk), .reset(reset), .stop(stop), .tick(tick), .gun_arttir(gun_arttir),
    .gun_azalt(gun_azalt), .ay(ay), .leap(leap), .load(load), .load_val(load_val),
    .gun(gun_f), .ay_arttir(arttir_f), .ay_azalt(azalt_f), .gun_son(son_f)
  );

  typedef struct {
    int gun;
    bit arm;
    bit pend;
    bit inc;
    bit dec;
  } st_t;

  st_t m_cal, m_fix;

  function automatic int mlen(int m, int fl, bit lp);
    int days[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (fl != 0) return fl;
    if (m < 1 || m > 12) return 31;
    if (m == 2) return lp ? 29 : 28;
    return days[m-1];
  endfunction

  // One clock of the calendar rules applied to the currently driven inputs.
  function automatic st_t nxt(st_t s, int fl);
    st_t n = s;
    int  L, P, pm;
    bit  btn, tev;
    n.inc = 0;
    n.dec = 0;
    if (reset) begin
      n.gun = 1; n.arm = 1; n.pend = 0;
      return n;
    end
    pm  = (ay <= 1 || ay > 12) ? 12 : int'(ay) - 1;
    L   = mlen(int'(ay), fl, leap);
    P   = mlen(pm, fl, leap);
    btn = s.arm && (gun_arttir != gun_azalt);
    tev = (tick || s.pend) && !stop;
    n.arm = !gun_arttir && !gun_azalt;
    if (load) begin
      n.gun = (load_val == 0) ? 1 : (int'(load_val) > L ? L : int'(load_val));
      if (tev) n.pend = 1;
    end else if (btn) begin
      if (gun_arttir) begin
        if (s.gun < L) n.gun = s.gun + 1;
        else begin n.gun = 1; n.inc = 1; end
      end else begin
        if (s.gun > 1) n.gun = s.gun - 1;
        else begin n.gun = P; n.dec = 1; end
      end
      if (tev) n.pend = 1;
    end else if (tev) begin
      if (s.gun < L) n.gun = s.gun + 1;
      else begin n.gun = 1; n.inc = 1; end
      n.pend = 0;
    end else if (s.gun > L) begin
      n.gun = L;
    end
    return n;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_cal = nxt(m_cal, 0);
    m_fix = nxt(m_fix, 30);
    #1;
    check("cal.gun", int'(gun_c), m_cal.gun);
    check("cal.ay_arttir", int'(arttir_c), int'(m_cal.inc));
    check("cal.ay_azalt", int'(azalt_c), int'(m_cal.dec));
    check("cal.gun_son", int'(son_c), int'(m_cal.gun == mlen(int'(ay), 0, leap)));
    check("fix.gun", int'(gun_f), m_fix.gun);
    check("fix.ay_arttir", int'(arttir_f), int'(m_fix.inc));
    check("fix.ay_azalt", int'(azalt_f), int'(m_fix.dec));
    check("fix.gun_son", int'(son_f), int'(m_fix.gun == 30));
  endtask

  task automatic do_load(input int v);
    load = 1; load_val = 6'(v);
    step();
    load = 0;
  endtask

  initial begin
    m_cal = '{gun: 1, arm: 1, pend: 0, inc: 0, dec: 0};
    m_fix = m_cal;
    reset = 1; stop = 0; tick = 0; gun_arttir = 1; gun_azalt = 0;
    ay = 4'd1; leap = 0; load = 0; load_val = '0;

    // Reset with increment held: exactly one increment afterwards.
    step();
    check("reset.gun", int'(gun_c), 1);
    reset = 0;
    for (int i = 0; i < 10; i++) step();
    check("held_press_once", int'(gun_c), 2);
    gun_arttir = 0; step();
    gun_arttir = 1; step();
    check("new_press", int'(gun_c), 3);
    gun_arttir = 0; step();

    // February wrap, non-leap and leap.
    ay = 4'd2; leap = 0; do_load(28);
    tick = 1; step(); tick = 0;
    check("feb28.gun", int'(gun_c), 1);
    check("feb28.carry", int'(arttir_c), 1);
    step();
    check("carry_one_cycle", int'(arttir_c), 0);
    leap = 1; do_load(28);
    tick = 1; step(); tick = 0;
    check("feb29.gun", int'(gun_c), 29);
    check("feb29.nocarry", int'(arttir_c), 0);

    // Decrement borrow into Feb (leap) and into December.
    ay = 4'd3; do_load(1);
    gun_azalt = 1; step(); gun_azalt = 0;
    check("borrow_feb.gun", int'(gun_c), 29);
    check("borrow_feb.pulse", int'(azalt_c), 1);
    step();
    ay = 4'd1; do_load(1);
    gun_azalt = 1; step(); gun_azalt = 0;
    check("borrow_dec.gun", int'(gun_c), 31);
    check("borrow_dec.pulse", int'(azalt_c), 1);
    step();

    // Button and tick together: tick deferred one cycle.
    do_load(15);
    gun_arttir = 1; tick = 1; step(); tick = 0;
    check("btn_tick.first", int'(gun_c), 16);
    step(); gun_arttir = 0;
    check("btn_tick.pend", int'(gun_c), 17);
    step();
    do_load(15);
    stop = 1; gun_arttir = 1; tick = 1; step(); tick = 0;
    check("stop.first", int'(gun_c), 16);
    step(); gun_arttir = 0; stop = 0;
    check("stop.no_tick", int'(gun_c), 16);
    step();

    // Clamp on month change and clamped load.
    ay = 4'd1; do_load(31);
    ay = 4'd4; step();
    check("clamp.gun", int'(gun_c), 30);
    do_load(0);
    check("load0", int'(gun_c), 1);
    do_load(40);
    check("load40", int'(gun_c), 30);

    // Fixed 30-day instance in February.
    ay = 4'd2; leap = 0; do_load(30);
    tick = 1; step(); tick = 0;
    check("fix.wrap.gun", int'(gun_f), 1);
    check("fix.wrap.carry", int'(arttir_f), 1);
    do_load(29);
    tick = 1; step(); tick = 0;
    check("fix.nowrap28", int'(gun_f), 30);

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      stop  = ($urandom_range(0, 9) == 0);
      tick  = ($urandom_range(0, 4) == 0);
      leap  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) ay = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) gun_arttir = ~gun_arttir;
      if ($urandom_range(0, 7) == 0) gun_azalt = ~gun_azalt;
      load = !gun_arttir && !gun_azalt && ($urandom_range(0, 19) == 0);
      load_val = 6'($urandom_range(0, 63));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
